// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared pipeline types for the front end (IF/ID latch layout, fetch FSM states).
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef struct packed {
    word_t instr;
    word_t npc;
    logic  valid;
  } ifid_t;
  typedef enum logic {FETCH, HALTED} fetch_state_t;
  localparam ifid_t IFID_BUBBLE = '{instr: '0, npc: '0, valid: 1'b0};
  function automatic word_t sat_inc(input word_t v);
    return (&v) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline latch; flush loads a bubble and overrides enable, otherwise holds.
module ifid_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  i_en,
  input  logic  i_flush,
  input  ifid_t i_d,
  output ifid_t o_q
);
  ifid_t r_q;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) r_q <= IFID_BUBBLE;
    else if (i_flush) r_q <= IFID_BUBBLE;
    else if (i_en) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC and fetch FSM, drives the icache request and fills the IF/ID latch.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t       PC_INIT = 32'h0000_0000,
  parameter int unsigned PC_STEP = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        mem_stall,
  input  logic        hazard,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);
  word_t        r_pc, r_cnt;
  fetch_state_t r_state;
  ifid_t        w_d, w_q;
  logic         w_quiet, w_stall, w_redir, w_fetch, w_flush;
  word_t        w_npc, w_target;
  assign w_npc    = r_pc + word_t'(PC_STEP);
  assign w_target = branch ? branch_target : jump_target;
  assign w_quiet  = (r_state == HALTED) | halt;
  assign w_stall  = mem_stall | hazard;
  assign w_redir  = branch | jump;
  assign w_fetch  = !w_quiet & !w_stall & !w_redir & ihit;
  // a miss or redirect sends a bubble downstream; a stall keeps IF/ID frozen
  assign w_flush  = w_quiet | (!w_stall & (w_redir | !ihit));
  assign w_d      = '{instr: iload, npc: w_npc, valid: 1'b1};
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_pc    <= PC_INIT;
      r_cnt   <= '0;
      r_state <= FETCH;
    end else begin
      if (halt) r_state <= HALTED;
      if (!w_quiet && !w_stall && w_redir) r_pc <= w_target;
      else if (w_fetch) r_pc <= w_npc;
      if (w_fetch) r_cnt <= sat_inc(r_cnt);
    end
  ifid_reg u_ifid (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_en    (w_fetch),
    .i_flush (w_flush),
    .i_d     (w_d),
    .o_q     (w_q)
  );
  assign imemREN     = (r_state == FETCH);
  assign imemaddr    = r_pc;
  assign ifid_instr  = w_q.instr;
  assign ifid_npc    = w_q.npc;
  assign ifid_valid  = w_q.valid;
  assign fetch_count = r_cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed literal checks plus randomized run against a behavioural fetch model.
module tb_fetch_stage;
  logic        CLK = 0, nRST = 1;
  logic        ihit = 0, mem_stall = 0, hazard = 0, branch = 0, jump = 0, halt = 0;
  logic [31:0] iload = 0, branch_target = 0, jump_target = 0;
  logic        imemREN, ifid_valid;
  logic [31:0] imemaddr, ifid_instr, ifid_npc, fetch_count;
  int          n_cmp = 0, n_bad = 0;

  fetch_stage dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .mem_stall(mem_stall),
    .hazard(hazard), .branch(branch), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .halt(halt), .imemREN(imemREN), .imemaddr(imemaddr),
    .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .ifid_valid(ifid_valid),
    .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: priority rules applied directly to plain variables
  logic [31:0] m_pc, m_instr, m_npc, m_cnt;
  logic        m_valid, m_halted;
  always @(posedge CLK or negedge nRST)
    if (!nRST) begin
      m_pc <= 0; m_instr <= 0; m_npc <= 0; m_valid <= 0; m_cnt <= 0; m_halted <= 0;
    end else if (m_halted || halt) begin
      m_halted <= 1; m_instr <= 0; m_npc <= 0; m_valid <= 0;
    end else if (mem_stall || hazard) begin
      m_halted <= 0;
    end else if (branch || jump) begin
      m_pc <= branch ? branch_target : jump_target;
      m_instr <= 0; m_npc <= 0; m_valid <= 0;
    end else if (ihit) begin
      m_pc <= m_pc + 4; m_instr <= iload; m_npc <= m_pc + 4; m_valid <= 1;
      m_cnt <= (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
    end else begin
      m_instr <= 0; m_npc <= 0; m_valid <= 0;
    end

  always @(negedge CLK)
    if (nRST) begin
      chk("imemREN", 32'(imemREN), 32'(!m_halted));
      chk("imemaddr", imemaddr, m_pc);
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_npc", ifid_npc, m_npc);
      chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
      chk("fetch_count", fetch_count, m_cnt);
    end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set(input logic h, input logic s, input logic hz, input logic b,
                     input logic [31:0] bt, input logic j, input logic [31:0] jt);
    ihit = h; mem_stall = s; hazard = hz; branch = b; branch_target = bt; jump = j; jump_target = jt;
  endtask

  initial begin
    #1 nRST = 0;
    #9;
    chk("rst_addr", imemaddr, 32'h0);
    chk("rst_ren", 32'(imemREN), 32'h1);
    chk("rst_valid", 32'(ifid_valid), 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    #2 nRST = 1;
    iload = 32'h2008_0005;
    set(1, 0, 0, 0, 0, 0, 0);
    step();
    chk("seq1_addr", imemaddr, 32'h4);
    chk("seq1_npc", ifid_npc, 32'h4);
    chk("seq1_instr", ifid_instr, 32'h2008_0005);
    chk("seq1_count", fetch_count, 32'h1);
    step();
    chk("seq2_addr", imemaddr, 32'h8);
    chk("seq2_npc", ifid_npc, 32'h8);
    hazard = 1;
    repeat (2) step();
    chk("haz_addr", imemaddr, 32'h8);
    chk("haz_npc", ifid_npc, 32'h8);
    chk("haz_valid", 32'(ifid_valid), 32'h1);
    chk("haz_count", fetch_count, 32'h2);
    hazard = 0;
    step();
    chk("resume_addr", imemaddr, 32'hC);
    chk("resume_count", fetch_count, 32'h3);
    set(1, 0, 0, 1, 32'h40, 0, 0);
    step();
    chk("br_addr", imemaddr, 32'h40);
    chk("br_valid", 32'(ifid_valid), 32'h0);
    chk("br_count", fetch_count, 32'h3);
    set(1, 0, 0, 0, 0, 0, 0);
    step();
    chk("br_fetch_addr", imemaddr, 32'h44);
    set(1, 0, 0, 1, 32'h40, 1, 32'h80);
    step();
    chk("brjmp_addr", imemaddr, 32'h40);
    set(1, 0, 1, 1, 32'h100, 0, 0);
    step();
    chk("hazbr_addr", imemaddr, 32'h40);
    set(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("miss_addr", imemaddr, 32'h40);
      chk("miss_valid", 32'(ifid_valid), 32'h0);
    end
    set(0, 0, 0, 0, 0, 1, 32'h80);
    step();
    chk("missjmp_addr", imemaddr, 32'h80);
    chk("missjmp_count", fetch_count, 32'h4);
    set(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    step();
    set(1, 0, 0, 0, 0, 0, 0);
    step();
    chk("wrap_addr", imemaddr, 32'h0);
    chk("wrap_npc", ifid_npc, 32'h0);
    chk("wrap_valid", 32'(ifid_valid), 32'h1);
    chk("wrap_count", fetch_count, 32'h5);
    for (int i = 0; i < 2000; i++) begin
      step();
      ihit = ($urandom_range(3) != 0);
      iload = $urandom;
      mem_stall = ($urandom_range(7) == 0);
      hazard = ($urandom_range(7) == 0);
      branch = ($urandom_range(7) == 0);
      jump = ($urandom_range(7) == 0);
      branch_target = {$urandom_range(32'h3FFF_FFFF), 2'b00};
      jump_target = {$urandom_range(32'h3FFF_FFFF), 2'b00};
      if (i == 700 || i == 1400) begin
        #1 nRST = 0;
        #1;
        chk("midrst_addr", imemaddr, 32'h0);
        chk("midrst_count", fetch_count, 32'h0);
        chk("midrst_valid", 32'(ifid_valid), 32'h0);
        nRST = 1;
      end
    end
    halt = 1;
    step();
    chk("halt_ren", 32'(imemREN), 32'h0);
    chk("halt_valid", 32'(ifid_valid), 32'h0);
    for (int i = 0; i < 30; i++) begin
      halt = $urandom_range(1);
      ihit = 1; iload = $urandom; branch = $urandom_range(1); branch_target = 32'h40;
      step();
    end
    chk("halted_ren", 32'(imemREN), 32'h0);
    #1 nRST = 0;
    #1;
    chk("final_rst_addr", imemaddr, 32'h0);
    chk("final_rst_ren", 32'(imemREN), 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
